alsu_cmd_sequencer: RTL and testbench

ALSU_CMD_SEQUENCER -- requirements
Module: alsu_cmd_sequencer

---
 rtl/alsu_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alsu_cmd_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer
// Buffers packed ALSU commands in a small FIFO and issues them one at a time
// to an external ALSU. Each result is captured once the ALSU's two register
// stages have settled, and is then offered downstream until accepted.
//
// Ports
//    clk, rst         rising-edge clock, asynchronous active-high reset
//    cmd_valid        upstream command offered
//    cmd_ready        FIFO has room; transfer on cmd_valid && cmd_ready
//    cmd_data         {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
//                      bypass_A, bypass_B, direction}
//    alsu_*           registered command fields driven into the ALSU
//    alsu_out         ALSU result
//    alsu_leds        ALSU leds, non-zero flags an invalid operation
//    res_valid        captured result available
//    res_ready        downstream accepts; transfer on res_valid && res_ready
//    res_data         captured ALSU result
//    res_invalid      alsu_leds was non-zero when the result was captured
module alsu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_data,
   output logic [2:0]  alsu_A,
   output logic [2:0]  alsu_B,
   output logic [2:0]  alsu_opcode,
   output logic        alsu_cin,
   output logic        alsu_serial_in,
   output logic        alsu_red_op_A,
   output logic        alsu_red_op_B,
   output logic        alsu_bypass_A,
   output logic        alsu_bypass_B,
   output logic        alsu_direction,
   input  logic [5:0]  alsu_out,
   input  logic [15:0] alsu_leds,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [5:0]  res_data,
   output logic        res_invalid
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_STEP   = AW'(1);
   localparam logic [AW:0]   CNT_STEP   = (AW+1)'(1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      RESP
   } state_t;

   state_t        state_q;
   logic [15:0]   fifoMem_q [FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic          push;
   logic          pop;
   logic [15:0]   headCmd;

   // A full FIFO refuses new commands even when a pop happens in the same
   // cycle, so a stalled upstream command simply waits one more cycle.
   assign cmd_ready = (count_q != FULL_COUNT);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign headCmd   = fifoMem_q[rdPtr_q];

   // Next pointer and occupancy values; a simultaneous push and pop leaves
   // the occupancy unchanged while both pointers advance.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_STEP;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_STEP;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_STEP;
      end else if (!push && pop) begin
         count_d = count_q - CNT_STEP;
      end
   end

   // FIFO bookkeeping registers. Reset empties the queue at once; stale
   // storage contents are never read because the count is zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // FIFO storage needs no reset since the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= cmd_data;
      end
   end

   // Issue/capture sequencer. The alsu_* registers keep the last issued
   // command applied, so the ALSU keeps re-executing it; ISSUE and WAIT
   // cover the ALSU's input and output register stages before CAPTURE
   // samples the result exactly once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         alsu_opcode    <= '0;
         alsu_A         <= '0;
         alsu_B         <= '0;
         alsu_cin       <= 1'b0;
         alsu_serial_in <= 1'b0;
         alsu_red_op_A  <= 1'b0;
         alsu_red_op_B  <= 1'b0;
         alsu_bypass_A  <= 1'b0;
         alsu_bypass_B  <= 1'b0;
         alsu_direction <= 1'b0;
         res_valid      <= 1'b0;
         res_data       <= '0;
         res_invalid    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
                   alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
                   alsu_bypass_B, alsu_direction} <= headCmd;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               res_data    <= alsu_out;
               res_invalid <= (alsu_leds != '0);
               res_valid   <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// tb_alsu_cmd_sequencer
// Drives alsu_cmd_sequencer against a behavioural ALSU (INPUT_PRIORITY="A",
// FULL_ADDER="ON", registered inputs and outputs) and compares results with
// a queue-based reference model of the expected command results.
module tb_alsu_cmd_sequencer;

   localparam int FIFO_DEPTH = 4;
   localparam int RAND_CMDS  = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data;
   logic [2:0]  alsu_A, alsu_B, alsu_opcode;
   logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
   logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
   logic [5:0]  alsu_out;
   logic [15:0] alsu_leds;
   logic        res_valid;
   logic        res_ready;
   logic [5:0]  res_data;
   logic        res_invalid;

   logic [15:0] alsuBus;
   logic [15:0] aluIn;

   int checkCount  = 0;
   int passCount   = 0;
   int failCount   = 0;
   int resultCount = 0;
   logic [15:0] expQ [$];

   assign alsuBus = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
                     alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
                     alsu_bypass_B, alsu_direction};

   always #5 clk = ~clk;

   alsu_cmd_sequencer #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_data(cmd_data),
      .alsu_A(alsu_A),
      .alsu_B(alsu_B),
      .alsu_opcode(alsu_opcode),
      .alsu_cin(alsu_cin),
      .alsu_serial_in(alsu_serial_in),
      .alsu_red_op_A(alsu_red_op_A),
      .alsu_red_op_B(alsu_red_op_B),
      .alsu_bypass_A(alsu_bypass_A),
      .alsu_bypass_B(alsu_bypass_B),
      .alsu_direction(alsu_direction),
      .alsu_out(alsu_out),
      .alsu_leds(alsu_leds),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data(res_data),
      .res_invalid(res_invalid)
   );

   // Invalid operation: not bypassed, and either opcode 6/7 or a reduction
   // requested on an opcode other than OR/XOR.
   function automatic logic refInvalid(input logic [15:0] c);
      return !(c[2] || c[1]) &&
             ((c[15:13] >= 3'd6) || ((c[4] || c[3]) && (c[15:13] >= 3'd2)));
   endfunction

   // Expected ALSU result for a non-shifting command, as signed integers.
   function automatic logic [5:0] refResult(input logic [15:0] c);
      int a, b, r;
      a = int'($signed(c[12:10]));
      b = int'($signed(c[9:7]));
      r = 0;
      if (c[2]) r = a;
      else if (c[1]) r = b;
      else if (refInvalid(c)) r = 0;
      else begin
         case (c[15:13])
            3'd0: r = c[4] ? int'(c[12:10] != 3'd0) : (c[3] ? int'(c[9:7] != 3'd0) : (a | b));
            3'd1: r = c[4] ? ($countones(c[12:10]) % 2) : (c[3] ? ($countones(c[9:7]) % 2) : (a ^ b));
            3'd2: r = a + b + int'(c[6]);
            3'd3: r = a * b;
            default: r = 0;
         endcase
      end
      return r[5:0];
   endfunction

   function automatic logic [15:0] mkCmd(input logic [2:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic [6:0] ctl);
      return {op, a, b, ctl};
   endfunction

   // Random valid, non-shifting command so its result is history-free.
   function automatic logic [15:0] randCmd();
      logic [15:0] c;
      c = 16'($urandom);
      c[15:13] = 3'($urandom_range(0, 3));
      if (c[15:13] >= 3'd2) c[4:3] = 2'b00;
      if ($urandom_range(0, 3) != 0) c[2:1] = 2'b00;
      return c;
   endfunction

   // Behavioural ALSU: input register stage, then output register stage
   // that re-executes the applied command every cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aluIn     <= '0;
         alsu_out  <= '0;
         alsu_leds <= '0;
      end else begin
         aluIn <= alsuBus;
         if (aluIn[2] || aluIn[1]) begin
            alsu_out  <= refResult(aluIn);
            alsu_leds <= '0;
         end else if (refInvalid(aluIn)) begin
            alsu_out  <= '0;
            alsu_leds <= ~alsu_leds;
         end else if (aluIn[15:13] == 3'd4) begin
            alsu_out  <= aluIn[0] ? {alsu_out[4:0], aluIn[5]} : {aluIn[5], alsu_out[5:1]};
            alsu_leds <= '0;
         end else if (aluIn[15:13] == 3'd5) begin
            alsu_out  <= aluIn[0] ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
            alsu_leds <= '0;
         end else begin
            alsu_out  <= refResult(aluIn);
            alsu_leds <= '0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rr);
      cmd_valid = v;
      cmd_data  = d;
      res_ready = rr;
   endtask

   // Called right after driving at a negedge: a result handshake here
   // completes on the coming posedge.
   task automatic scoreStep();
      logic [15:0] head;
      if (res_valid && res_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 16'(res_data), 16'hFFFF);
         end else begin
            head = expQ.pop_front();
            checkOutput("sb_data", 16'(res_data), 16'(refResult(head)));
            checkOutput("sb_invalid", 16'(res_invalid), 16'(refInvalid(head)));
            resultCount++;
         end
      end
   endtask

   task automatic awaitResult(input string tag, input logic [5:0] expData,
                              input logic expInv, input int holdCycles);
      int waited = 0;
      while (!res_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_arrived"}, 16'(res_valid), 16'd1);
      checkOutput({tag, "_data"}, 16'(res_data), 16'(expData));
      checkOutput({tag, "_invalid"}, 16'(res_invalid), 16'(expInv));
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, 16'(res_valid), 16'd1);
         checkOutput({tag, "_hold_data"}, 16'(res_data), 16'(expData));
      end
      applyStimulus(1'b0, 16'h0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput({tag, "_dropped"}, 16'(res_valid), 16'd0);
   endtask

   task automatic pushCmd(input string tag, input logic [15:0] c);
      applyStimulus(1'b1, c, 1'b0);
      checkOutput({tag, "_cmd_ready"}, 16'(cmd_ready), 16'd1);
      @(negedge clk);
      applyStimulus(1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      logic [15:0] c;
      logic [15:0] lastCmd;
      logic [5:0]  heldData;
      logic        heldInv;
      bit          heldPrev;
      bit          pending6;
      int          sent, target, seenValid;
      int          times [$];

      rst = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst_cmd_ready", 16'(cmd_ready), 16'd1);
      checkOutput("rst_res_valid", 16'(res_valid), 16'd0);
      checkOutput("rst_res_data", 16'(res_data), 16'd0);
      checkOutput("rst_res_invalid", 16'(res_invalid), 16'd0);
      checkOutput("rst_alsu", alsuBus, 16'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] OR command latency");
      c = mkCmd(3'd0, 3'd1, 3'd2, 7'b0);
      pushCmd("or", c);
      @(negedge clk);
      checkOutput("or_issue_alsu", alsuBus, c);
      repeat (2) @(negedge clk);
      checkOutput("or_not_yet_valid", 16'(res_valid), 16'd0);
      @(negedge clk);
      checkOutput("or_latency_valid", 16'(res_valid), 16'd1);
      awaitResult("or", 6'h03, 1'b0, 2);
      checkOutput("or_alsu_hold", alsuBus, c);

      $display("[TB] shift result sampled once while ALSU keeps shifting");
      pushCmd("shift", mkCmd(3'd4, 3'd0, 3'd0, 7'b0100001));
      awaitResult("shift", 6'h07, 1'b0, 3);

      $display("[TB] add then multiply in push order");
      applyStimulus(1'b1, mkCmd(3'd2, 3'd3, 3'd2, 7'b1000000), 1'b0);
      checkOutput("add_cmd_ready", 16'(cmd_ready), 16'd1);
      @(negedge clk);
      applyStimulus(1'b1, mkCmd(3'd3, 3'b110, 3'd3, 7'b0), 1'b0);
      checkOutput("mul_cmd_ready", 16'(cmd_ready), 16'd1);
      @(negedge clk);
      applyStimulus(1'b0, 16'h0, 1'b0);
      awaitResult("add", 6'h06, 1'b0, 2);
      awaitResult("mul", 6'h3A, 1'b0, 0);

      $display("[TB] invalid opcode and bypass");
      pushCmd("inv", mkCmd(3'd6, 3'd1, 3'd2, 7'b0));
      awaitResult("inv", 6'h00, 1'b1, 0);
      pushCmd("byp", mkCmd(3'd6, 3'd1, 3'b111, 7'b0000010));
      awaitResult("byp", 6'h3F, 1'b0, 0);

      $display("[TB] backpressure fills the FIFO");
      for (int i = 0; i < 5; i++) begin
         c = randCmd();
         applyStimulus(1'b1, c, 1'b0);
         checkOutput("fill_cmd_ready", 16'(cmd_ready), 16'd1);
         expQ.push_back(c);
         @(negedge clk);
      end
      lastCmd = randCmd();
      applyStimulus(1'b1, lastCmd, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("full_cmd_ready", 16'(cmd_ready), 16'd0);
         checkOutput("full_res_valid", 16'(res_valid), 16'd1);
         checkOutput("full_res_data", 16'(res_data), 16'(refResult(expQ[0])));
         @(negedge clk);
      end
      pending6 = 1'b1;
      target = resultCount + 6;
      for (int cyc = 0; cyc < 200 && resultCount < target; cyc++) begin
         applyStimulus(pending6, lastCmd, 1'b1);
         if (pending6 && cmd_ready) begin
            expQ.push_back(lastCmd);
            pending6 = 1'b0;
         end
         scoreStep();
         @(negedge clk);
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("sixth_accepted", 16'(pending6), 16'd0);
      checkOutput("drain_results", 16'(resultCount), 16'(target));

      $display("[TB] throughput with res_ready held high");
      target = resultCount + 3;
      for (int cyc = 0; cyc < 60 && resultCount < target; cyc++) begin
         if (cyc < 3) begin
            c = randCmd();
            applyStimulus(1'b1, c, 1'b1);
            checkOutput("thr_cmd_ready", 16'(cmd_ready), 16'd1);
            expQ.push_back(c);
         end else begin
            applyStimulus(1'b0, 16'h0, 1'b1);
         end
         if (res_valid) times.push_back(cyc);
         scoreStep();
         @(negedge clk);
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("thr_results", 16'(times.size()), 16'd3);
      if (times.size() == 3) begin
         checkOutput("thr_first", 16'(times[0]), 16'd5);
         checkOutput("thr_gap1", 16'(times[1] - times[0]), 16'd5);
         checkOutput("thr_gap2", 16'(times[2] - times[1]), 16'd5);
      end

      $display("[TB] randomized traffic");
      sent = 0;
      heldPrev = 1'b0;
      heldData = '0;
      heldInv = 1'b0;
      target = resultCount + RAND_CMDS;
      for (int cyc = 0; cyc < 3000 && resultCount < target; cyc++) begin
         if (heldPrev) begin
            checkOutput("rand_hold_valid", 16'(res_valid), 16'd1);
            checkOutput("rand_hold_data", 16'(res_data), 16'(heldData));
            checkOutput("rand_hold_invalid", 16'(res_invalid), 16'(heldInv));
         end
         applyStimulus((sent < RAND_CMDS) && ($urandom_range(0, 2) != 0), randCmd(),
                       $urandom_range(0, 9) < 5);
         if (cmd_valid && cmd_ready) begin
            expQ.push_back(cmd_data);
            sent++;
         end
         heldPrev = res_valid && !res_ready;
         heldData = res_data;
         heldInv  = res_invalid;
         scoreStep();
         @(negedge clk);
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("rand_results", 16'(resultCount), 16'(target));
      checkOutput("rand_queue_empty", 16'(expQ.size()), 16'd0);

      $display("[TB] reset during WAIT with two commands queued");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, randCmd(), 1'b0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 16'h0, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_cmd_ready", 16'(cmd_ready), 16'd1);
      checkOutput("midrst_res_valid", 16'(res_valid), 16'd0);
      @(negedge clk);
      checkOutput("midrst_alsu", alsuBus, 16'h0);
      rst = 1'b0;
      seenValid = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (res_valid) seenValid++;
      end
      checkOutput("midrst_no_result", 16'(seenValid), 16'd0);
      checkOutput("midrst_alsu_idle", alsuBus, 16'h0);
      checkOutput("midrst_cmd_ready_idle", 16'(cmd_ready), 16'd1);
      applyStimulus(1'b0, 16'h0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
